bit_serializer: RTL and testbench
=================================

// Module: bit_serializer
// PURPOSE
//  Upstream feeder for the serial sequence-detector FSM (fsm: clk, rst, din, dout).
//  - Accepts a parallel WIDTH-bit word over a valid/ready handshake.
//  - Shifts the word out MSB-first, one bit per clk, on ser_out, which drives the FSM's din.
//  - Inserts GAP idle cycles between words.
// PARAMETERS
//  WIDTH      8  data word width in bits; legal range >= 2
//  GAP        1  ser_out cycles held at IDLE_LEVEL after each word; legal range >= 0
//  IDLE_LEVEL 0  ser_out value while not shifting (1'b0 or 1'b1)
// PORTS
//  clk         in   1      system clock, rising edge
//  rst         in   1      synchronous reset, active-high
//  data_in     in   WIDTH  parallel word; sampled only on the accept edge
//  data_valid  in   1      producer has a word
//  data_ready  out  1      block can accept; transfer = data_valid & data_ready at posedge clk
//  ser_out     out  1      serial bit stream (registered) -> fsm din
//  ser_valid   out  1      high while ser_out carries a word bit (or parity bit)
//  busy        out  1      high in any state other than IDLE
//  word_done   out  1      one-cycle pulse coincident with the last serial bit of a word
// BEHAVIOUR
//  - Single clock. Synchronous active-high reset. All state updates occur on posedge clk.
//  - Reset values: state=IDLE, ser_out=IDLE_LEVEL, ser_valid=0, busy=0, word_done=0.
//    data_ready is forced to 0 while rst=1.
//  - FSM states and transitions:
//    IDLE -(accept)-> SHIFT -(last data bit)-> [PARITY] -> GAP -(GAP cycles done)-> IDLE
//    - SHIFT goes straight to IDLE when GAP=0.
//  - data_ready = (state==IDLE) & ~rst. data_ready is combinational from registered state.
//  - Accept edge:
//    - Latch data_in into the shift register; bit counter=0.
//    - ser_out <= data_in[WIDTH-1], ser_valid <= 1.
//  - Latency: the first bit appears on ser_out in the cycle right after the accept edge.
//  - SHIFT: each edge presents the next lower bit. WIDTH consecutive ser_valid cycles,
//    with bit 0 last.
//  - word_done=1 only in the cycle carrying the final bit of the word.
//  - GAP: ser_out=IDLE_LEVEL, ser_valid=0, busy=1, data_ready=0.
//  - Throughput: one word per WIDTH+GAP+1 cycles with data_valid held high.
//    The IDLE cycle is the accept cycle.
//  - data_in and data_valid are ignored outside IDLE. Changes mid-word do not alter the bits
//    being shifted out.
//  - Reset mid-word:
//    - Abort immediately; the partial word is discarded and word_done is not issued.
//    - The next edge after rst deasserts may accept a new word.
//  - The bit counter is $clog2(WIDTH+1) bits wide and never wraps past WIDTH.
// CONFIGURATION
//  SER_PARITY_EN defined:
//    - After bit 0, one extra cycle (state PARITY) with ser_out = ^word (even parity)
//      and ser_valid=1.
//    - word_done moves to the parity cycle.
//    - Throughput becomes WIDTH+GAP+2 cycles per word.
//  SER_PARITY_EN undefined: no PARITY state; behaviour exactly as above.
// TESTING  (WIDTH=8, GAP=1, IDLE_LEVEL=0, clk period 20 ns)
//  1. rst=1 for 400 ns with data_valid=1, data_in=8'hA5
//     -> data_ready=0, ser_out=0, ser_valid=0 throughout.
//     Accept occurs on the first edge after rst=0.
//  2. Single word 8'hA5
//     -> ser_out = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with ser_valid=1;
//        word_done only on the 8th; then 1 GAP cycle; then data_ready=1.
//  3. Back-to-back 8'hFF then 8'h00 with data_valid held high
//     -> first bits of the two words are exactly 10 cycles apart;
//        ser_out=0 and ser_valid=0 in the GAP cycle and the IDLE cycle between words.
//  4. Accept 8'hF0, assert rst for 1 cycle after 3 bits
//     -> next cycle ser_valid=0, ser_out=0, no word_done;
//        new word 8'h3C then serializes fully as 0,0,1,1,1,1,0,0.
//  5. With SER_PARITY_EN: 8'hA5 -> 9th bit 0; 8'h07 -> 9th bit 1.
//     word_done is on the 9th bit in both cases.
//  6. Toggle data_in every cycle during SHIFT; also hold data_valid=0 for 50 cycles
//     -> shifted bits match the accepted word; with no valid, the block stays in IDLE
//        with ser_out=0.

Source files
------------

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - MSB-first parallel-to-serial feeder with inter-word idle gap
// Optional feature macro: SER_PARITY_EN (appends an even-parity bit after bit 0)
module bit_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   GAP        = 1,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             word_done
);

  localparam int CW       = $clog2(WIDTH + 1);
  localparam int GW       = (GAP > 1) ? $clog2(GAP) : 1;
  localparam int GAP_LAST = (GAP > 0) ? GAP - 1 : 0;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PARITY,
    ST_GAP
  } state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             ser_out_n, ser_valid_n, word_done_n;
`ifdef SER_PARITY_EN
  logic             par, par_n;
`endif

  // Ready is only offered from the idle state and never while reset is held.
  assign data_ready = (state == ST_IDLE) && !rst;
  assign busy       = (state != ST_IDLE);

  // Next-state and next-output decode; every serial output is registered.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    cnt_n       = cnt;
    gcnt_n      = gcnt;
    ser_out_n   = IDLE_LEVEL;
    ser_valid_n = 1'b0;
    word_done_n = 1'b0;
`ifdef SER_PARITY_EN
    par_n       = par;
`endif
    case (state)
      ST_IDLE: begin
        if (data_valid) begin
          // The MSB goes straight to ser_out; the rest wait at the top of shreg.
          state_n     = ST_SHIFT;
          shreg_n     = {data_in[WIDTH-2:0], 1'b0};
          cnt_n       = '0;
          ser_out_n   = data_in[WIDTH-1];
          ser_valid_n = 1'b1;
`ifdef SER_PARITY_EN
          par_n       = ^data_in;
`endif
        end
      end
      ST_SHIFT: begin
        // cnt is the index (from the MSB) of the bit currently on ser_out.
        if (cnt != CNT_LAST) begin
          cnt_n       = cnt + CW'(1);
          ser_out_n   = shreg[WIDTH-1];
          ser_valid_n = 1'b1;
          shreg_n     = {shreg[WIDTH-2:0], 1'b0};
`ifndef SER_PARITY_EN
          word_done_n = (cnt == CNT_PEN);
`endif
        end else begin
`ifdef SER_PARITY_EN
          state_n     = ST_PARITY;
          ser_out_n   = par;
          ser_valid_n = 1'b1;
          word_done_n = 1'b1;
`else
          state_n     = (GAP > 0) ? ST_GAP : ST_IDLE;
          gcnt_n      = '0;
`endif
        end
      end
`ifdef SER_PARITY_EN
      ST_PARITY: begin
        state_n = (GAP > 0) ? ST_GAP : ST_IDLE;
        gcnt_n  = '0;
      end
`endif
      ST_GAP: begin
        if (gcnt == GW'(GAP_LAST)) begin
          state_n = ST_IDLE;
        end else begin
          gcnt_n = gcnt + GW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      shreg     <= '0;
      cnt       <= '0;
      gcnt      <= '0;
      ser_out   <= IDLE_LEVEL;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
`ifdef SER_PARITY_EN
      par       <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      gcnt      <= gcnt_n;
      ser_out   <= ser_out_n;
      ser_valid <= ser_valid_n;
      word_done <= word_done_n;
`ifdef SER_PARITY_EN
      par       <= par_n;
`endif
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - self-checking bench for bit_serializer against a queue-based stream model
module tb_bit_serializer;

  localparam int W   = 8;
  localparam int GAP = 1;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic         clk;
  logic         rst;
  logic [W-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         busy;
  logic         word_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int accepts = 0;
  logic prev_v = 1'b0;
  logic [2:0] q[$];     // expected {ser_out, ser_valid, word_done} per upcoming cycle
  int starts[$];        // cycle numbers where a word's first bit was seen

  bit_serializer #(.WIDTH(W), .GAP(GAP), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .ser_out(ser_out), .ser_valid(ser_valid),
    .busy(busy), .word_done(word_done)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle: compare current outputs to the model, then advance across the edge.
  task automatic tick();
    logic       r, acc;
    logic [W-1:0] w;
    logic [2:0] e;
    #2;
    e = (q.size() > 0) ? q[0] : 3'b000;
    chk("data_ready", int'(data_ready), int'((q.size() == 0) && !rst));
    chk("busy", int'(busy), int'(q.size() != 0));
    chk("ser_out", int'(ser_out), int'(e[2]));
    chk("ser_valid", int'(ser_valid), int'(e[1]));
    chk("word_done", int'(word_done), int'(e[0]));
    if (ser_valid === 1'b1 && prev_v == 1'b0) starts.push_back(cyc);
    prev_v = (ser_valid === 1'b1);
    r   = rst;
    acc = (q.size() == 0) && !rst && data_valid;
    w   = data_in;
    @(posedge clk);
    #1;
    cyc++;
    if (q.size() > 0) void'(q.pop_front());
    if (r) q.delete();
    if (acc) begin
      accepts++;
      for (int i = W - 1; i >= 0; i--) q.push_back({w[i], 1'b1, (i == 0) && (PB == 0)});
      if (PB != 0) q.push_back({^w, 1'b1, 1'b1});
      for (int g = 0; g < GAP; g++) q.push_back(3'b000);
    end
  endtask

  initial begin
    rst = 1'b1;
    data_valid = 1'b1;
    data_in = 8'hA5;
    @(posedge clk);
    #1;
    cyc = 1;

    // Reset held 400 ns with a word pending, then single word 8'hA5.
    repeat (20) tick();
    rst = 1'b0;
    tick();
    chk("accept_after_rst", accepts, 1);
    data_valid = 1'b0;
    repeat (12) tick();

    // Back-to-back 8'hFF then 8'h00 with valid held.
    starts.delete();
    accepts = 0;
    for (int k = 0; k < 24; k++) begin
      data_in    = (accepts == 0) ? 8'hFF : 8'h00;
      data_valid = (accepts < 2);
      tick();
    end
    chk("b2b_accepts", accepts, 2);
    chk("b2b_words_seen", starts.size(), 2);
    if (starts.size() >= 2)
      chk("b2b_spacing", starts[1] - starts[0], W + GAP + 1 + PB);

    // Reset after 3 bits of 8'hF0, then 8'h3C immediately afterwards.
    data_in = 8'hF0;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    data_in = 8'h3C;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    repeat (12) tick();

    // Inputs toggling mid-word, then a long stretch with no valid.
    data_in = 8'h5A;
    data_valid = 1'b1;
    tick();
    for (int k = 0; k < 10; k++) begin
      data_in    = 8'($urandom);
      data_valid = 1'($urandom);
      tick();
    end
    data_valid = 1'b0;
    for (int k = 0; k < 50; k++) begin
      data_in = 8'($urandom);
      tick();
    end

    // Parity reference words (parity bits appear only in the SER_PARITY_EN build).
    data_in = 8'hA5; data_valid = 1'b1; tick();
    data_valid = 1'b0; repeat (11) tick();
    data_in = 8'h07; data_valid = 1'b1; tick();
    data_valid = 1'b0; repeat (11) tick();

    // Random traffic with occasional resets.
    for (int k = 0; k < 400; k++) begin
      data_in    = 8'($urandom);
      data_valid = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 39) == 0);
      tick();
    end
    rst = 1'b0;
    data_valid = 1'b0;
    repeat (12) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
